// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: UART-fed program loader and cpu test sequencer.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data/valid     incoming UART byte stream; rx_ready accepts a byte
//   mem_we/addr/wdata shared IMEM/DMEM word write port
//   cpu_rst           cpu core reset, low only while the program runs
//   csr               tohost CSR from the cpu
//   done/pass/timeout/error, cycle_count  test status
module prog_load_ctrl #(
    parameter int ADDR_WIDTH     = 14,
    parameter int RESET_HOLD     = 10,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    input  logic [31:0]           csr,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic                  error,
    output logic [31:0]           cycle_count
);
    typedef enum logic [2:0] {IDLE, HDR, CHK, DATA, HOLD, RUN, DONE, ERR} state_t;
    localparam logic [32:0] MEM_WORDS = 33'd1 << ADDR_WIDTH;
    state_t state, state_n;
    logic armed;
    logic acc;
    logic hdr_bad;
    logic [2:0] hdr_cnt;
    logic [63:0] hdr;
    logic [1:0] byte_cnt;
    logic [23:0] word;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0] left;
    logic [31:0] hold_cnt;
    // armed keeps rx_ready low for the first cycle out of reset
    assign rx_ready = armed && (state == IDLE || state == HDR || (state == DATA && left != 32'd0));
    assign acc = rx_valid && rx_ready;
    assign cpu_rst = state != RUN;
    // hdr[31:0] is ADDR, hdr[63:32] is LEN; end-of-range compared at 33 bits so it cannot wrap
    assign hdr_bad = hdr[1:0] != 2'd0 || hdr[63:32] == 32'd0 ||
                     ({3'b0, hdr[31:2]} + {1'b0, hdr[63:32]}) > MEM_WORDS;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (acc && rx_data == 8'hA5) ? HDR : IDLE;
            HDR:     state_n = (acc && hdr_cnt == 3'd7) ? CHK : HDR;
            CHK:     state_n = hdr_bad ? ERR : DATA;
            DATA:    state_n = (mem_we && left == 32'd0) ? HOLD : DATA;
            HOLD:    state_n = (hold_cnt == 32'(RESET_HOLD - 1)) ? RUN : HOLD;
            RUN:     state_n = (csr != 32'd0 || cycle_count == 32'(TIMEOUT_CYCLES - 1)) ? DONE : RUN;
            default: state_n = state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            hdr_cnt     <= '0;
            hdr         <= '0;
            byte_cnt    <= '0;
            word        <= '0;
            ptr         <= '0;
            left        <= '0;
            hold_cnt    <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            error       <= 1'b0;
            cycle_count <= '0;
        end else begin
            armed  <= 1'b1;
            mem_we <= 1'b0;
            if (state == HDR && acc) begin
                hdr     <= {rx_data, hdr[63:8]};
                hdr_cnt <= hdr_cnt + 3'd1;
            end
            if (state == CHK) begin
                ptr      <= hdr[ADDR_WIDTH+1:2];
                left     <= hdr[63:32];
                byte_cnt <= '0;
                error    <= hdr_bad;
            end
            if (state == DATA && acc) begin
                word     <= {rx_data, word[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= ptr;
                    mem_wdata <= {rx_data, word};
                    ptr       <= ptr + 1'b1;
                    left      <= left - 32'd1;
                end
            end
            if (state == HOLD)
                hold_cnt <= hold_cnt + 32'd1;
            // a csr result beats a simultaneous timeout; the count freezes on completion
            if (state == RUN) begin
                if (csr != 32'd0) begin
                    done <= 1'b1;
                    pass <= csr == 32'd1;
                end else if (cycle_count == 32'(TIMEOUT_CYCLES - 1)) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    cycle_count <= cycle_count + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed, table-driven bench for prog_load_ctrl.
module tb_prog_load_ctrl;
    localparam int AW = 14;
    localparam int HOLD_C = 10;
    localparam int TO = 100;
    typedef struct {
        logic [31:0] csr_val;
        int          at;
        logic        exp_pass;
        logic        exp_to;
        logic [31:0] exp_cnt;
    } run_vec_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic        exp_err;
    } hdr_vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic rx_valid = 1'b0;
    logic [31:0] csr = 32'd0;
    logic rx_ready, mem_we, cpu_rst, done, pass, timeout, error;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, cycle_count;
    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    logic [31:0] mem [0:(1<<AW)-1];
    run_vec_t rv [5];
    hdr_vec_t hv [5];
    prog_load_ctrl #(.ADDR_WIDTH(AW), .RESET_HOLD(HOLD_C), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .csr(csr), .done(done), .pass(pass), .timeout(timeout), .error(error),
        .cycle_count(cycle_count)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt++;
            wr_cyc = cyc;
        end
    end
    task automatic step();
        @(posedge clk);
        #2;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic expire(input string name);
        checks++;
        errs++;
        $display("FAIL %s: wait expired", name);
    endtask
    task automatic do_reset();
        rx_valid = 1'b0;
        csr = 32'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_valid = 1'b0;
        repeat (gap) step();
        rx_data = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n == 100) expire("rx_ready");
        step();
        rx_valid = 1'b0;
    endtask
    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], int'($urandom_range(maxgap, 0)));
    endtask
    task automatic send_hdr(input logic [31:0] addr, input logic [31:0] len, input int maxgap);
        send_byte(8'hA5, 0);
        send_word(addr, maxgap);
        send_word(len, maxgap);
    endtask
    task automatic load_prog();
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_hdr(32'h0, 32'd2, 0);
        send_word(32'h13, 0);
        send_word(32'h6F, 0);
    endtask
    task automatic wait_run(output int t);
        int n;
        n = 0;
        while (cpu_rst !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        if (n == 300) expire("wait_run");
        t = cyc;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int t, n, base;
        logic [31:0] d1 [16];
        logic [31:0] d2 [16];
        rv[0] = '{32'h1, 50, 1'b1, 1'b0, 32'd50};
        rv[1] = '{32'h3, 20, 1'b0, 1'b0, 32'd20};
        rv[2] = '{32'h0, -1, 1'b0, 1'b1, 32'd99};
        rv[3] = '{32'h1, 99, 1'b1, 1'b0, 32'd99};
        rv[4] = '{32'h2, 0,  1'b0, 1'b0, 32'd0};
        hv[0] = '{32'h0000_0002, 32'd1, 1'b1};
        hv[1] = '{32'h0000_FFFC, 32'd2, 1'b1};
        hv[2] = '{32'h0000_0000, 32'd0, 1'b1};
        hv[3] = '{32'h0001_0000, 32'd1, 1'b1};
        hv[4] = '{32'h0000_FFF8, 32'd2, 1'b0};
        for (int i = 0; i < 16; i++) begin
            d1[i] = 32'h1111_0000 + 32'(i);
            d2[i] = $urandom;
        end
        do_reset();
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_status", {28'd0, done, pass, timeout, error}, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        step();
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);
        base = wr_cnt;
        load_prog();
        wait_run(t);
        chk("t1_writes", 32'(wr_cnt - base), 32'd2);
        chk("t1_mem0", mem[0], 32'h13);
        chk("t1_mem1", mem[1], 32'h6F);
        chk("t1_rst_hold", 32'(t - wr_cyc), 32'(HOLD_C + 1));
        chk("t1_first_count", cycle_count, 32'd0);
        chk("t1_run_rx_ready", {31'd0, rx_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_prog();
            wait_run(t);
            n = 0;
            if (rv[i].at >= 0) begin
                while (cycle_count != 32'(rv[i].at) && n < 200) begin
                    step();
                    n++;
                end
                if (n == 200) expire($sformatf("run%0d_reach", i));
                chk($sformatf("run%0d_done_pre", i), {31'd0, done}, 32'd0);
                csr = rv[i].csr_val;
                step();
            end else begin
                while (done !== 1'b1 && n < 200) begin
                    step();
                    n++;
                end
                if (n == 200) expire($sformatf("run%0d_timeout_wait", i));
            end
            chk($sformatf("run%0d_done", i), {31'd0, done}, 32'd1);
            chk($sformatf("run%0d_pass", i), {31'd0, pass}, {31'd0, rv[i].exp_pass});
            chk($sformatf("run%0d_timeout", i), {31'd0, timeout}, {31'd0, rv[i].exp_to});
            chk($sformatf("run%0d_count", i), cycle_count, rv[i].exp_cnt);
            chk($sformatf("run%0d_cpu_rst", i), {31'd0, cpu_rst}, 32'd1);
            csr = 32'd0;
            repeat (3) step();
            chk($sformatf("run%0d_count_held", i), cycle_count, rv[i].exp_cnt);
            chk($sformatf("run%0d_status_held", i), {29'd0, done, pass, timeout},
                {29'd0, 1'b1, rv[i].exp_pass, rv[i].exp_to});
        end
        for (int i = 0; i < 5; i++) begin
            do_reset();
            base = wr_cnt;
            send_hdr(hv[i].addr, hv[i].len, 0);
            if (!hv[i].exp_err)
                for (int j = 0; j < int'(hv[i].len); j++) send_word(32'hC0DE_0000 | 32'(j), 0);
            repeat (3) step();
            chk($sformatf("hdr%0d_error", i), {31'd0, error}, {31'd0, hv[i].exp_err});
            chk($sformatf("hdr%0d_done", i), {31'd0, done}, 32'd0);
            chk($sformatf("hdr%0d_rx_ready", i), {31'd0, rx_ready}, 32'd0);
            chk($sformatf("hdr%0d_cpu_rst", i), {31'd0, cpu_rst}, 32'd1);
            chk($sformatf("hdr%0d_writes", i), 32'(wr_cnt - base), hv[i].exp_err ? 32'd0 : hv[i].len);
            if (!hv[i].exp_err)
                for (int j = 0; j < int'(hv[i].len); j++)
                    chk($sformatf("hdr%0d_mem%0d", i, j), mem[AW'(hv[i].addr >> 2) + AW'(j)],
                        32'hC0DE_0000 | 32'(j));
        end
        do_reset();
        base = wr_cnt;
        send_hdr(32'h100, 32'd16, 2);
        for (int i = 0; i < 7; i++) send_word(d1[i], 2);
        send_byte(d1[7][7:0], 1);
        send_byte(d1[7][15:8], 1);
        step();
        rst = 1'b1;
        step();
        chk("t6_rst_outputs", {25'd0, cpu_rst, rx_ready, mem_we, done, pass, timeout, error}, 32'h40);
        chk("t6_rst_addr", 32'(mem_addr), 32'd0);
        chk("t6_rst_wdata", mem_wdata, 32'd0);
        chk("t6_rst_count", cycle_count, 32'd0);
        chk("t6_partial_writes", 32'(wr_cnt - base), 32'd7);
        chk("t6_partial_mem6", mem[AW'(32'h46)], d1[6]);
        rst = 1'b0;
        step();
        base = wr_cnt;
        send_hdr(32'h100, 32'd16, 2);
        for (int i = 0; i < 16; i++) send_word(d2[i], 2);
        wait_run(t);
        chk("t6_reload_writes", 32'(wr_cnt - base), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("t6_mem%0d", i), mem[AW'(32'h40 + i)], d2[i]);
        n = 0;
        while (cycle_count != 32'd5 && n < 200) begin
            step();
            n++;
        end
        if (n == 200) expire("t6_reach");
        csr = 32'd1;
        step();
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_pass", {31'd0, pass}, 32'd1);
        chk("t6_timeout", {31'd0, timeout}, 32'd0);
        chk("t6_count", cycle_count, 32'd5);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
